// File: rtl/mul_add_reconstruct.sv
// Sequential shift-and-add unit: product = multiplicand*multiplier + addend, one multiplier
// bit per cycle; rebuilds a divider's dividend from (divisor, quotient, remainder) and checks it.
module mul_add_reconstruct #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   addend,
    input  logic [2*WIDTH-1:0] expected,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               match
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    mcand_q;
    logic [PW-1:0]    exp_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             match_q;
    logic [PW-1:0]    acc_d;

    // Accumulator value after the current iteration; the add cannot overflow 2*WIDTH bits.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            exp_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        acc_q    <= {{WIDTH{1'b0}}, addend};
                        mcand_q  <= {{WIDTH{1'b0}}, multiplicand};
                        mplier_q <= multiplier;
                        exp_q    <= expected;
                        cnt_q    <= '0;
                        state_q  <= S_BUSY;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        match_q  <= 1'b0;
                    end
                end
                S_BUSY: begin
                    // Fixed WIDTH iterations: no early exit when the multiplier runs out of ones.
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        match_q <= (acc_d == exp_q);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    match_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = acc_q;
    assign match   = match_q;

endmodule

// File: tb/tb_mul_add_reconstruct.sv
// Self-checking bench for mul_add_reconstruct: directed cases plus divider-output sweeps at
// WIDTH=4 (exhaustive) and WIDTH=8 (random), checked against plain integer arithmetic.
module tb_mul_add_reconstruct;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        start4 = 1'b0;
    logic [3:0]  mc4 = '0, mp4 = '0, ad4 = '0;
    logic [7:0]  ex4 = '0;
    logic        busy4, done4, match4;
    logic [7:0]  product4;

    logic        start8 = 1'b0;
    logic [7:0]  mc8 = '0, mp8 = '0, ad8 = '0;
    logic [15:0] ex8 = '0;
    logic        busy8, done8, match8;
    logic [15:0] product8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_add_reconstruct #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .multiplicand(mc4), .multiplier(mp4), .addend(ad4), .expected(ex4),
        .busy(busy4), .done(done4), .product(product4), .match(match4)
    );

    mul_add_reconstruct #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .multiplicand(mc8), .multiplier(mp8), .addend(ad8), .expected(ex8),
        .busy(busy8), .done(done8), .product(product8), .match(match8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full WIDTH=4 operation; operands are scrambled right after the accept edge.
    task automatic op4(input string tag, input int mc, input int mp, input int ad, input int ex);
        int prod;
        prod = mc * mp + ad;
        mc4 = 4'(mc); mp4 = 4'(mp); ad4 = 4'(ad); ex4 = 8'(ex);
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        mc4 = 4'($urandom); mp4 = 4'($urandom); ad4 = 4'($urandom); ex4 = 8'($urandom);
        check({tag, ".acc_busy"}, 32'(busy4), 32'(1));
        check({tag, ".acc_done"}, 32'(done4), 32'(0));
        check({tag, ".acc_match"}, 32'(match4), 32'(0));
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("%s.busy%0d", tag, i), 32'(busy4), 32'(i < 4));
            check($sformatf("%s.done%0d", tag, i), 32'(done4), 32'(i == 4));
        end
        check({tag, ".product"}, 32'(product4), 32'(prod));
        check({tag, ".match"}, 32'(match4), 32'(prod == ex));
    endtask

    task automatic op8(input string tag, input int mc, input int mp, input int ad, input int ex);
        int prod;
        prod = mc * mp + ad;
        mc8 = 8'(mc); mp8 = 8'(mp); ad8 = 8'(ad); ex8 = 16'(ex);
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        mc8 = 8'($urandom); mp8 = 8'($urandom); ad8 = 8'($urandom); ex8 = 16'($urandom);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            check($sformatf("%s.busy%0d", tag, i), 32'(busy8), 32'(i < 8));
            check($sformatf("%s.done%0d", tag, i), 32'(done8), 32'(i == 8));
        end
        check({tag, ".product"}, 32'(product8), 32'(prod));
        check({tag, ".match"}, 32'(match8), 32'(prod == ex));
    endtask

    initial begin
        int v, q, r, p;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst.busy4", 32'(busy4), 32'(0));
        check("rst.done4", 32'(done4), 32'(0));
        check("rst.match4", 32'(match4), 32'(0));
        check("rst.product4", 32'(product4), 32'(0));
        check("rst.busy8", 32'(busy8), 32'(0));
        check("rst.product8", 32'(product8), 32'(0));
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("idle.done4", 32'(done4), 32'(0));
            check("idle.busy4", 32'(busy4), 32'(0));
        end

        // Directed cases
        op4("basic", 3, 5, 2, 17);
        op4("max_match", 15, 15, 15, 240);
        op4("max_miss", 15, 15, 15, 241);
        op4("mplier0", 9, 0, 7, 7);
        op4("mcand0", 0, 9, 7, 7);

        // DONE holds with no start
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold.done", 32'(done4), 32'(1));
            check("hold.busy", 32'(busy4), 32'(0));
            check("hold.product", 32'(product4), 32'(7));
        end

        // start while busy (and on the done edge) is ignored; start on done cycle restarts
        mc4 = 4'd3; mp4 = 4'd5; ad4 = 4'd2; ex4 = 8'd17;
        start4 = 1'b1;
        @(posedge clk); #1;
        mc4 = 4'd9; mp4 = 4'd9; ad4 = 4'd9; ex4 = 8'd0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("ign.busy%0d", i), 32'(busy4), 32'(i < 4));
            check($sformatf("ign.done%0d", i), 32'(done4), 32'(i == 4));
        end
        check("ign.product", 32'(product4), 32'(17));
        check("ign.match", 32'(match4), 32'(1));
        op4("b2b", 2, 6, 1, 13);

        // Asynchronous reset two cycles into an operation
        mc4 = 4'd3; mp4 = 4'd5; ad4 = 4'd2; ex4 = 8'd17;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        check("pre_rst.busy", 32'(busy4), 32'(1));
        rst = 1'b1;
        #1;
        check("arst.busy", 32'(busy4), 32'(0));
        check("arst.done", 32'(done4), 32'(0));
        check("arst.match", 32'(match4), 32'(0));
        check("arst.product", 32'(product4), 32'(0));
        #3 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst.busy", 32'(busy4), 32'(0));
            check("post_rst.done", 32'(done4), 32'(0));
            check("post_rst.product", 32'(product4), 32'(0));
        end
        op4("after_rst", 7, 11, 4, 81);

        // WIDTH=4 exhaustive divider outputs: quotient must fit in 4 bits
        for (int dv = 1; dv < 16; dv++) begin
            for (int dd = 0; dd < 256; dd++) begin
                if (dd / dv < 16) op4("div4", dv, dd / dv, dd % dv, dd);
            end
        end

        // WIDTH=4 random operands with a sometimes-wrong expected value
        for (int n = 0; n < 100; n++) begin
            v = int'($urandom_range(0, 15)); q = int'($urandom_range(0, 15));
            r = int'($urandom_range(0, 15));
            p = $urandom_range(0, 1) != 0 ? v * q + r : int'($urandom_range(0, 255));
            op4("rnd4", v, q, r, p);
        end

        // WIDTH=8 random divider outputs
        op8("max8", 255, 255, 255, 65280);
        for (int n = 0; n < 200; n++) begin
            v = int'($urandom_range(1, 255)); q = int'($urandom_range(0, 255));
            r = int'($urandom_range(0, v - 1));
            op8("div8", v, q, r, v * q + r);
        end
        for (int n = 0; n < 50; n++) begin
            v = int'($urandom_range(0, 255)); q = int'($urandom_range(0, 255));
            r = int'($urandom_range(0, 255));
            p = $urandom_range(0, 1) != 0 ? v * q + r : int'($urandom_range(0, 65535));
            op8("rnd8", v, q, r, p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
